imm_extend_pipe: RTL
====================

# imm_extend_pipe

Parametrised, registered immediate/operand extension stage for the datapath's decode-to-execute path. It accepts an IN_W-bit field plus a mode and a destination tag over a valid/ready handshake. It produces an OUT_W-bit sign-, zero-, upper-, branch- or byte-extended result one cycle later. A 2-entry skid buffer sustains one result per cycle under downstream back-pressure, and a synchronous flush squashes in-flight entries on branch/jump redirects.

## Interface
- IN_W, default 16: width of input immediate; legal range 8..OUT_W.
- OUT_W, default 32: width of extended result; must be ≥ IN_W.
- TAG_W, default 5: width of the sideband tag (destination register number).
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  reset; one clock, asynchronous, active-low.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  input entry present.
- in_ready  out  1  stage can accept; registered.
- in_data  in  IN_W  raw immediate field.
- in_mode  in  3  extension mode (encodings below).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag of out_data.
- out_err  out  1  result came from an illegal mode.

## Operation
- Modes:
  - 0 SEXT: replicate in_data[IN_W-1] into the upper OUT_W-IN_W bits.
  - 1 ZEXT: upper bits 0.
  - 2 UPPER: in_data placed at [OUT_W-1:OUT_W-IN_W], low bits 0 (LUI for 16/32).
  - 3 BRANCH: SEXT result << 2, truncated to OUT_W; the two LSBs are 0.
  - 4 SEXT_B: sign-extend in_data[7:0].
  - 5 ZEXT_B: zero-extend in_data[7:0].
  - 6, 7 illegal: out_data = 0, out_err = 1. The entry still flows; no other side effect.
- Handshake:
  - A transfer occurs when valid && ready are high on the same edge.
  - out_valid, once high, holds out_data, out_tag and out_err stable until accepted.
  - in_ready never depends combinationally on out_ready.
- States, by occupancy:
  - EMPTY: no entries; out_valid = 0; in_ready = 1.
  - ONE: main register full; out_valid = 1; in_ready = 1.
  - TWO: main and skid registers full; out_valid = 1; in_ready = 0.
- Transitions (acc = input transfer, pop = output transfer):
  - EMPTY: acc → ONE.
  - ONE: acc && !pop → TWO; !acc && pop → EMPTY; acc && pop → ONE, with the new entry in main.
  - TWO: pop → ONE, with the skid entry moving to main.
- Order is strictly FIFO. The extension is computed before capture, so registers hold final results.
- flush has priority over everything:
  - Next state is EMPTY.
  - Any input accepted in the flush cycle is discarded.
  - A pop on the flush cycle still completes for the current output.
- Reset values: out_valid = 0, out_data = 0, out_tag = 0, out_err = 0, in_ready = 1, state = EMPTY.
- Reset mid-operation drops all entries immediately and asynchronously.

## Timing
- Latency: input accepted at edge N appears on out_* after edge N, i.e. valid in cycle N+1.
- Throughput: 1 entry per cycle while out_ready = 1.
- in_ready falls the cycle after the second entry is held while out_ready = 0. It rises the cycle after a pop from TWO.
- Flush asserted in cycle N gives out_valid = 0 and in_ready = 1 in cycle N+1.
- Reset deassertion must be synchronised externally. The first transfer is legal on the first edge after Rst_n rises.

## Structure
- Shared package ext_pkg holds:
  - mode encodings as localparams: EXT_SEXT, EXT_ZEXT, EXT_UPPER, EXT_BRANCH, EXT_SEXT_B, EXT_ZEXT_B.
  - occupancy state encodings: ST_EMPTY, ST_ONE, ST_TWO.
- Sub-module ext_core is the purely combinational extender, parametrised on IN_W/OUT_W, producing {err, data}. imm_extend_pipe instantiates it once, on the input side.
- The skid/occupancy control stays in imm_extend_pipe.

## Test plan
- Modes at defaults, out_ready = 1:
  - in_data 16'h8004, mode 0 → 32'hFFFF8004.
  - mode 1 → 32'h00008004.
  - mode 2 → 32'h80040000.
  - mode 3 → 32'hFFFE0010.
  - in_data 16'h0080, mode 4 → 32'hFFFFFF80; mode 5 → 32'h00000080.
  - Each result arrives 1 cycle after the transfer.
- Illegal mode 6 with tag 5'd9 → out_data 0, out_err 1, out_tag 9. The next entry (mode 0) has out_err 0.
- Back-pressure:
  - Hold out_ready = 0 and stream A, B, C.
  - A and B are accepted; in_ready = 0 from the cycle after B; C is held by the source.
  - Release out_ready: outputs A, B, C in order, no loss or duplication.
- Flush in state TWO, with in_valid = 1 in the same cycle → next cycle out_valid = 0, in_ready = 1; the flushed and concurrent inputs never appear.
- Asynchronous reset:
  - Pull Rst_n low mid-stream, between edges → all outputs reach their reset values without a clock edge.
  - After release, the first entry 16'h7FFF mode 0 → 32'h00007FFF.
- Parameter sweep IN_W = 8, OUT_W = 16: in_data 8'h90 mode 0 → 16'hFF90; mode 2 → 16'h9000; mode 3 → 16'hFE40.

Source files
------------

// File: rtl/ext_pkg.sv
// Shared encodings for the immediate extension stage: extension modes and
// skid-buffer occupancy states.
package ext_pkg;

  localparam logic [2:0] EXT_SEXT   = 3'd0;
  localparam logic [2:0] EXT_ZEXT   = 3'd1;
  localparam logic [2:0] EXT_UPPER  = 3'd2;
  localparam logic [2:0] EXT_BRANCH = 3'd3;
  localparam logic [2:0] EXT_SEXT_B = 3'd4;
  localparam logic [2:0] EXT_ZEXT_B = 3'd5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extender; res = {err, data}. Modes 6/7 give err with zero data.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0] data,
  input  logic [2:0]      mode,
  output logic [OUT_W:0]  res
);

  logic [OUT_W-1:0] sext, zext, sext_b, zext_b;

  assign sext   = OUT_W'($signed(data));
  assign zext   = OUT_W'(data);
  assign sext_b = OUT_W'($signed(data[7:0]));
  assign zext_b = OUT_W'(data[7:0]);

  always_comb begin
    res = '0;
    case (mode)
      EXT_SEXT:   res = {1'b0, sext};
      EXT_ZEXT:   res = {1'b0, zext};
      EXT_UPPER:  res = {1'b0, zext << (OUT_W - IN_W)};
      EXT_BRANCH: res = {1'b0, sext << 2};
      EXT_SEXT_B: res = {1'b0, sext_b};
      EXT_ZEXT_B: res = {1'b0, zext_b};
      default:    res = {1'b1, {OUT_W{1'b0}}};
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extension stage with a 2-entry skid buffer and flush.
// Extension happens before capture so both registers hold final results.
module imm_extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  logic [OUT_W-1:0] ext_data, skid_data;
  logic             ext_err, skid_err;
  logic [TAG_W-1:0] skid_tag;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .data (in_data),
    .mode (in_mode),
    .res  ({ext_err, ext_data})
  );

  occ_e state, state_nxt;
  logic acc, pop, load_main_in, load_main_skid, load_skid;

  // Both handshake outputs decode straight from the state register.
  assign in_ready  = (state != ST_TWO);
  assign out_valid = (state != ST_EMPTY);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (acc) begin
          state_nxt    = ST_ONE;
          load_main_in = 1'b1;
        end
        ST_ONE: begin
          if (acc && pop) begin
            load_main_in = 1'b1;
          end else if (acc) begin
            state_nxt = ST_TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          state_nxt      = ST_ONE;
          load_main_skid = 1'b1;
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      skid_data <= '0;
      skid_tag  <= '0;
      skid_err  <= 1'b0;
    end else begin
      if (load_main_in) begin
        out_data <= ext_data;
        out_tag  <= in_tag;
        out_err  <= ext_err;
      end else if (load_main_skid) begin
        out_data <= skid_data;
        out_tag  <= skid_tag;
        out_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= ext_data;
        skid_tag  <= in_tag;
        skid_err  <= ext_err;
      end
    end
  end

endmodule
